irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Interrupt arbiter for the design's interval-timer interrupt lines. It edge-detects up to `NUM_SRC` one-cycle `interrupting` pulses, typically from several `minipit` instances, and latches them as pending. It selects one enabled pending source and presents it as a single `irq_out`/`irq_id` request to the consumer, which retires it with `irq_ack`. The block sits between the timers and the top-level output pins or a future host interface.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources; legal range 2..16.
- `ID_W`, default 2: width of `irq_id`; must equal clog2(`NUM_SRC`).
---
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  block enable; tie to `ena`.
- `irq_src`  in  NUM_SRC  raw interrupt lines; a rising edge is an event.
- `mask`  in  NUM_SRC  1 = source may be granted; 0 = source stays pending but is not selected.
- `irq_ack`  in  1  consumer retires the current request.
- `overrun_clr`  in  1  clears all `overrun` bits.
- `irq_out`  out  1  request valid.
- `irq_id`  out  ID_W  index of the granted source; stable while `irq_out`=1.
- `pending`  out  NUM_SRC  latched events, masked or not.
- `overrun`  out  NUM_SRC  sticky: an event arrived while that source was already pending.

## Operation
- **Edge detection:** `prev` register holds last-cycle `irq_src`; `edge = irq_src & ~prev`.
  - `prev` resets to all-ones, so lines already high at reset release are not events.
- **Pending:** `pending[i]` is set on `edge[i]` and cleared when source i is acked.
  - If `edge[i]` and the ack of source i occur in the same cycle, `pending[i]` stays 1. The new event wins and does not count as an overrun.
- **Overrun:** `overrun[i]` is set when `edge[i]` occurs while `pending[i]`=1 and source i is not being acked that cycle.
  - `overrun_clr` clears all bits. If clear and set occur in the same cycle, set wins.
- **FSM `IDLE`:** `irq_out`=0. If `enable` and `(pending & mask)`≠0, register the winner into `irq_id` and go to `ASSERT`.
- **FSM `ASSERT`:** `irq_out`=1 and `irq_id` is held.
  - On `irq_ack`=1: clear `pending[irq_id]` and go to `IDLE`.
  - Masking the granted source during `ASSERT` does not retract the request.
- `irq_ack` is ignored in `IDLE`.
- **`enable`=0:**
  - Edge detection is suppressed; `prev` still tracks `irq_src`.
  - The FSM is forced to `IDLE`. `pending` and `overrun` are retained, and an un-acked grant stays pending.
- **Selection:** fixed priority, lowest index wins (see Configuration).
- **Reset:** all outputs 0, the FSM is in `IDLE`, and `pending`/`overrun` are 0. Reset mid-`ASSERT` drops `irq_out` on the next edge and loses all pending events.

## Timing
- An `irq_src` rise is sampled at edge t. `pending` is visible after edge t, and `irq_out`=1 after edge t+1: a 2-cycle latency from an idle arbiter.
- `irq_ack` is sampled at edge a:
  - `irq_out`=0 after edge a.
  - The earliest next `irq_out`=1 is after edge a+1.
  - Minimum low gap between requests is 1 cycle.
- `pending`/`overrun` update on the same edge as the triggering event.
- `irq_id` changes only on the `IDLE`→`ASSERT` edge.

## Configuration
- Macro `IRQ_ARBITER_ROUND_ROBIN_EN`.
- **Defined:** round-robin selection.
  - A `last` pointer (ID_W bits, reset 0) records the most recently granted index.
  - The search starts at `last+1` and wraps modulo `NUM_SRC`.
  - `last` updates on each grant.
- **Undefined:** fixed priority, lowest index wins, and no `last` register exists.

## Test plan
- **Single event:** pulse `irq_src[2]` for 1 cycle with `mask`=all ones → `irq_out`=1 and `irq_id`=2 two cycles later. Ack → `irq_out`=0 next cycle and `pending`=0.
- **Simultaneous events:** pulse sources 1 and 3 in the same cycle, acking each grant.
  - Fixed priority: grants in order 1, then 3.
  - Round-robin from `last`=1 with sources 1 and 3 pending again: grants 3, then 1.
- **Masking:** `mask[0]`=0, pulse source 0 → `pending[0]`=1 and `irq_out` stays 0. Set `mask[0]`=1 → `irq_out`=1 and `irq_id`=0 one cycle later.
- **Overrun:** pulse source 1 twice without ack → `overrun[1]`=1. Assert `overrun_clr` → `overrun[1]`=0. Then pulse source 1 in the same cycle as its ack → `pending[1]` stays 1 and `overrun[1]` stays 0.
- **Reset and enable:**
  - Hold `irq_src[0]`=1 through reset release → no event.
  - Drop `enable` during `ASSERT` → `irq_out`=0 next cycle. Re-enable → the same `irq_id` is re-presented.
  - Assert `rst_n`=0 mid-`ASSERT` → all outputs 0 after the next edge.

Source files
------------

// File: rtl/irq_arbiter.sv
// ----------------------------------------------------------------------------
// irq_arbiter
//
// Collects rising-edge events from up to NUM_SRC interval-timer interrupt
// lines, latches them as pending, and presents one enabled pending source at
// a time as a single irq_out/irq_id request.  The consumer retires the
// request with irq_ack.
//
// Selection policy is chosen at build time with IRQ_ARBITER_ROUND_ROBIN_EN:
//   undefined : fixed priority, lowest index wins
//   defined   : round robin, search starts one past the last granted index
//
// Parameters
//   NUM_SRC      number of interrupt sources (2..16)
//   ID_W         width of irq_id, equal to clog2(NUM_SRC)
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       block enable; low forces IDLE and suppresses event capture
//   irq_src      raw interrupt lines, a rising edge is an event
//   mask         1 = source may be granted, 0 = held pending only
//   irq_ack      consumer retires the current request
//   overrun_clr  clears all overrun bits
//   irq_out      request valid
//   irq_id       index of the granted source, stable while irq_out is high
//   pending      latched events, masked or not
//   overrun      sticky: event arrived while that source was already pending
//
// FSM states
//   state  | meaning
//   IDLE   | no request presented; grant a winner when enabled and one exists
//   ASSERT | irq_out high, irq_id held until ack or enable drops
// ----------------------------------------------------------------------------
module irq_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               irq_ack,
    input  logic               overrun_clr,
    output logic               irq_out,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] ack_vec;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] overrun_nxt;
    logic [ID_W-1:0]    irq_id_nxt;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    logic               ack_fire;
    logic               grant;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    last_nxt;

    // Index (base + off) wrapped modulo NUM_SRC; NUM_SRC need not be a
    // power of two, so plain ID_W-bit overflow is not enough.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int off);
        int v;
        v = (int'(base) + off) % NUM_SRC;
        return ID_W'(v);
    endfunction
`endif

    // prev keeps tracking the lines while disabled so that re-enabling with
    // a line already high does not manufacture an event.
    assign edge_det = enable ? (irq_src & ~prev) : '0;
    assign req      = pending & mask;

    // An ack is honoured whenever a request is being presented.
    assign ack_fire = (state == ASSERT) && irq_ack;
    assign ack_vec  = ack_fire ? (NUM_SRC'(1) << irq_id) : '0;

    // A fresh edge in the same cycle as its own ack re-arms pending and is
    // not an overrun, because the previous event is being retired.
    assign pending_nxt = (pending & ~ack_vec) | edge_det;
    assign overrun_nxt = (overrun_clr ? '0 : overrun)
                       | (edge_det & pending & ~ack_vec);

    // Winner selection
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && req[rr_index(last, k + 1)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last, k + 1);
            end
        end
`else
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(k);
            end
        end
`endif
    end

    assign grant = (state == IDLE) && enable && win_found;

    // Next-state and registered outputs
    always_comb begin
        state_nxt  = state;
        irq_id_nxt = irq_id;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt  = ASSERT;
                    irq_id_nxt = win_idx;
                end
            end
            ASSERT: begin
                // Masking the granted source does not retract the request;
                // only an ack or loss of enable ends it.
                if (!enable || irq_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    assign last_nxt = grant ? win_idx : last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq_id  <= '0;
            prev    <= '1;
            pending <= '0;
            overrun <= '0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            last    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            irq_id  <= irq_id_nxt;
            prev    <= irq_src;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            last    <= last_nxt;
`endif
        end
    end

    assign irq_out = (state == ASSERT);

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] mask;
    logic               irq_ack;
    logic               overrun_clr;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    int n_checks;
    int n_fail;

    irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .irq_src     (irq_src),
        .mask        (mask),
        .irq_ack     (irq_ack),
        .overrun_clr (overrun_clr),
        .irq_out     (irq_out),
        .irq_id      (irq_id),
        .pending     (pending),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns so outputs are sampled
    // away from the edge and the next inputs are set up for the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [ID_W-1:0] first_id;
    logic [ID_W-1:0] second_id;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        enable      = 1'b1;
        irq_src     = 4'b0001;
        mask        = 4'b1111;
        irq_ack     = 1'b0;
        overrun_clr = 1'b0;

        // Reset, with source 0 held high through release
        tick(); tick(); tick();
        check("rst_irq_out", 32'(irq_out), 32'd0);
        check("rst_irq_id",  32'(irq_id),  32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("held_line_pending", 32'(pending), 32'd0);
        check("held_line_irq_out", 32'(irq_out), 32'd0);
        irq_src = 4'b0000;
        tick();

        // Single event on source 2
        irq_src = 4'b0100;
        tick();
        check("single_pending", 32'(pending), 32'h4);
        check("single_out_early", 32'(irq_out), 32'd0);
        irq_src = 4'b0000;
        tick();
        check("single_irq_out", 32'(irq_out), 32'd1);
        check("single_irq_id",  32'(irq_id),  32'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("single_ack_out", 32'(irq_out), 32'd0);
        check("single_ack_pending", 32'(pending), 32'd0);
        // ack in IDLE must be ignored
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("idle_ack_out", 32'(irq_out), 32'd0);

        // Simultaneous events on 1 and 3, two rounds
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        first_id  = 2'd3;
        second_id = 2'd1;
`else
        first_id  = 2'd1;
        second_id = 2'd3;
`endif
        for (int r = 0; r < 2; r++) begin
            irq_src = 4'b1010;
            tick();
            check("sim_pending", 32'(pending), 32'hA);
            irq_src = 4'b0000;
            tick();
            check("sim_first_out", 32'(irq_out), 32'd1);
            check("sim_first_id",  32'(irq_id),  32'(first_id));
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            check("sim_gap_out", 32'(irq_out), 32'd0);
            check("sim_mid_pending", 32'(pending), 32'(4'b1010 & ~(4'b0001 << first_id)));
            tick();
            check("sim_second_out", 32'(irq_out), 32'd1);
            check("sim_second_id",  32'(irq_id),  32'(second_id));
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            check("sim_end_pending", 32'(pending), 32'd0);
        end

        // Masking
        mask    = 4'b1110;
        irq_src = 4'b0001;
        tick();
        check("mask_pending", 32'(pending), 32'h1);
        irq_src = 4'b0000;
        tick(); tick();
        check("mask_out_low", 32'(irq_out), 32'd0);
        mask = 4'b1111;
        tick();
        check("unmask_out", 32'(irq_out), 32'd1);
        check("unmask_id",  32'(irq_id),  32'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("unmask_ack_pending", 32'(pending), 32'd0);

        // Overrun
        irq_src = 4'b0010;
        tick();
        irq_src = 4'b0000;
        tick();
        check("ovr_grant_id", 32'(irq_id), 32'd1);
        irq_src = 4'b0010;
        tick();
        check("ovr_set", 32'(overrun), 32'h2);
        check("ovr_pending", 32'(pending), 32'h2);
        irq_src     = 4'b0000;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        irq_src = 4'b0010;
        irq_ack = 1'b1;
        tick();
        irq_src = 4'b0000;
        irq_ack = 1'b0;
        check("ack_edge_pending", 32'(pending), 32'h2);
        check("ack_edge_overrun", 32'(overrun), 32'd0);
        check("ack_edge_out", 32'(irq_out), 32'd0);
        tick();
        check("regrant_out", 32'(irq_out), 32'd1);
        check("regrant_id",  32'(irq_id),  32'd1);
        irq_src     = 4'b0010;
        overrun_clr = 1'b1;
        tick();
        irq_src = 4'b0000;
        check("ovr_set_wins", 32'(overrun), 32'h2);
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr2", 32'(overrun), 32'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ovr_end_pending", 32'(pending), 32'd0);

        // Enable drop during ASSERT
        irq_src = 4'b1000;
        tick();
        irq_src = 4'b0000;
        tick();
        check("en_grant_out", 32'(irq_out), 32'd1);
        check("en_grant_id",  32'(irq_id),  32'd3);
        enable = 1'b0;
        tick();
        check("dis_out", 32'(irq_out), 32'd0);
        check("dis_pending", 32'(pending), 32'h8);
        irq_src = 4'b0001;
        tick();
        check("dis_no_edge", 32'(pending), 32'h8);
        enable = 1'b1;
        tick();
        check("reen_out", 32'(irq_out), 32'd1);
        check("reen_id",  32'(irq_id),  32'd3);
        check("reen_pending", 32'(pending), 32'h8);
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b1000;
        tick();
        check("pre_rst_overrun", 32'(overrun), 32'h8);

        // Reset mid-ASSERT
        rst_n   = 1'b0;
        irq_src = 4'b0000;
        tick();
        check("midrst_out",     32'(irq_out), 32'd0);
        check("midrst_id",      32'(irq_id),  32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
